text_console_ctrl: RTL and testbench

//  Sequencer for the 80x30 text-mode tile RAM: pops bytes from the UART RX FIFO and drives the tile RAM write port.

---
 rtl/text_console_pkg.sv | 44 ++++
 rtl/text_console_ctrl_walker.sv | 41 ++++
 rtl/text_console_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_console_pkg.sv
// Shared constants, state encoding and RAM request payload for the text console.
package text_console_pkg;

    // Screen geometry defaults and cursor/address widths
    localparam int unsigned COLS_DEF = 80;
    localparam int unsigned ROWS_DEF = 30;
    localparam int unsigned XW       = 7;
    localparam int unsigned YW       = 5;
    localparam int unsigned AW       = XW + YW;
    localparam int unsigned CW       = 7;

    // Control codes and the fill character
    localparam logic [7:0]    CODE_CR    = 8'h0D;
    localparam logic [7:0]    CODE_LF    = 8'h0A;
    localparam logic [7:0]    CODE_BS    = 8'h08;
    localparam logic [7:0]    CODE_FF    = 8'h0C;
    localparam logic [7:0]    PRINT_LO   = 8'h20;
    localparam logic [7:0]    PRINT_HI   = 8'h7E;
    localparam logic [CW-1:0] BLANK      = 7'h20;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        WRITE  = 3'd2,
        SC_RD  = 3'd3,
        SC_WR  = 3'd4,
        SC_CLR = 3'd5,
        CLEAR  = 3'd6
    } state_t;

    // One tile RAM port-A access
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [CW-1:0] din;
    } ram_req_t;

    // Tile RAM address of cell (x,y)
    function automatic logic [AW-1:0] tile_addr(input logic [YW-1:0] y, input logic [XW-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/text_console_ctrl_walker.sv
// Row-major (x,y) cell counter shared by the scroll copy, scroll blank and full clear.
module tile_walker
    import text_console_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF,
    parameter int unsigned ROWS = ROWS_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [YW-1:0] start_row,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          done_c
);

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    // Position register: load has priority over step; last cell wraps to (0,0)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= '0;
            y <= start_row;
        end else if (step) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= done_c ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    assign done_c = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/text_console_ctrl.sv
// Text console sequencer: UART bytes and pushbuttons to tile RAM port A with cursor, scroll and clear.
module text_console_ctrl
    import text_console_pkg::*;
#(
    parameter int unsigned COLS = COLS_DEF,
    parameter int unsigned ROWS = ROWS_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_empty,
    output logic          rd_uart,
    input  logic          key_right,
    input  logic          key_down,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [CW-1:0] ram_din,
    input  logic [CW-1:0] ram_dout,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          busy
);

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    state_t        state;
    state_t        state_nx;
    logic [7:0]    byte_q;
    logic [7:0]    byte_nx;
    logic          erase_q;
    logic          erase_nx;
    logic [XW-1:0] x_nx;
    logic [YW-1:0] y_nx;

    logic          wk_load;
    logic          wk_step;
    logic [YW-1:0] wk_start;
    logic [XW-1:0] wk_x;
    logic [YW-1:0] wk_y;
    logic [YW-1:0] wk_y_up;
    logic          wk_done_c;

    ram_req_t      req;

    tile_walker #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_walker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (wk_load),
        .step      (wk_step),
        .start_row (wk_start),
        .x         (wk_x),
        .y         (wk_y),
        .done_c    (wk_done_c)
    );

    // Destination row of a scroll copy is the row above the source
    assign wk_y_up = wk_y - YW'(1);

    // State, cursor and latched-byte registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_x   <= '0;
            cur_y   <= '0;
            byte_q  <= '0;
            erase_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cur_x   <= x_nx;
            cur_y   <= y_nx;
            byte_q  <= byte_nx;
            erase_q <= erase_nx;
        end
    end

    // Next state, cursor updates and walker control
    always_comb begin
        state_nx = state;
        x_nx     = cur_x;
        y_nx     = cur_y;
        byte_nx  = byte_q;
        erase_nx = erase_q;
        wk_load  = 1'b0;
        wk_step  = 1'b0;
        wk_start = '0;

        case (state)
            IDLE: begin
                if (key_right) begin
                    x_nx = (cur_x == X_LAST) ? '0 : cur_x + XW'(1);
                end else if (key_down) begin
                    y_nx = (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
                end else if (!rx_empty) begin
                    byte_nx  = rx_data;
                    erase_nx = 1'b0;
                    state_nx = DECODE;
                end
            end

            DECODE: begin
                state_nx = IDLE;
                if ((byte_q >= PRINT_LO) && (byte_q <= PRINT_HI)) begin
                    state_nx = WRITE;
                end else if (byte_q == CODE_CR) begin
                    x_nx = '0;
                end else if (byte_q == CODE_LF) begin
                    if (cur_y != Y_LAST) begin
                        y_nx = cur_y + YW'(1);
                    end else begin
                        wk_load  = 1'b1;
                        wk_start = YW'(1);
                        state_nx = SC_RD;
                    end
                end else if (byte_q == CODE_BS) begin
                    // Backspace reuses WRITE to blank the cell it steps back onto
                    if (cur_x != '0) begin
                        x_nx     = cur_x - XW'(1);
                        erase_nx = 1'b1;
                        state_nx = WRITE;
                    end
                end else if (byte_q == CODE_FF) begin
                    wk_load  = 1'b1;
                    wk_start = '0;
                    state_nx = CLEAR;
                end
            end

            WRITE: begin
                state_nx = IDLE;
                if (!erase_q) begin
                    if (cur_x != X_LAST) begin
                        x_nx = cur_x + XW'(1);
                    end else begin
                        x_nx = '0;
                        if (cur_y != Y_LAST) begin
                            y_nx = cur_y + YW'(1);
                        end else begin
                            wk_load  = 1'b1;
                            wk_start = YW'(1);
                            state_nx = SC_RD;
                        end
                    end
                end
            end

            SC_RD: begin
                state_nx = SC_WR;
            end

            SC_WR: begin
                if (wk_done_c) begin
                    wk_load  = 1'b1;
                    wk_start = Y_LAST;
                    state_nx = SC_CLR;
                end else begin
                    wk_step  = 1'b1;
                    state_nx = SC_RD;
                end
            end

            SC_CLR: begin
                if (wk_done_c) begin
                    state_nx = IDLE;
                end else begin
                    wk_step = 1'b1;
                end
            end

            CLEAR: begin
                if (wk_done_c) begin
                    x_nx     = '0;
                    y_nx     = '0;
                    state_nx = IDLE;
                end else begin
                    wk_step = 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Port-A request, FIFO pop and busy decoded from the registered state
    always_comb begin
        req     = '0;
        rd_uart = 1'b0;
        busy    = (state != IDLE);

        case (state)
            DECODE: begin
                rd_uart = 1'b1;
            end
            WRITE: begin
                req.we   = 1'b1;
                req.addr = tile_addr(cur_y, cur_x);
                req.din  = erase_q ? BLANK : byte_q[CW-1:0];
            end
            SC_RD: begin
                req.addr = tile_addr(wk_y, wk_x);
            end
            SC_WR: begin
                // Read data of the SC_RD cell arrives this cycle and goes straight back out
                req.we   = 1'b1;
                req.addr = tile_addr(wk_y_up, wk_x);
                req.din  = ram_dout;
            end
            SC_CLR, CLEAR: begin
                req.we   = 1'b1;
                req.addr = tile_addr(wk_y, wk_x);
                req.din  = BLANK;
            end
            default: begin
                req = '0;
            end
        endcase
    end

    assign ram_we   = req.we;
    assign ram_addr = req.addr;
    assign ram_din  = req.din;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench: tile RAM and UART FIFO models plus a screen-level reference model.
module tb_text_console_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam logic [6:0] BLK = 7'h20;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rd_uart;
    logic        key_right;
    logic        key_down;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [6:0]  ram_din;
    logic [6:0]  ram_dout;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    text_console_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .rd_uart   (rd_uart),
        .key_right (key_right),
        .key_down  (key_down),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tile RAM port A (read-first, 1-clk read latency) with a bulk preload path
    logic [6:0] mem [0:4095];
    logic [6:0] img [0:4095];
    logic       fill_req = 1'b0;
    int         n_wr = 0;
    int         bad_wr = 0;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 4096; i++) mem[i] <= img[i];
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
            n_wr <= n_wr + 1;
            if ((ram_addr[6:0] >= 7'd80) || (ram_addr[11:7] >= 5'd30)) bad_wr <= bad_wr + 1;
        end
        ram_dout <= mem[ram_addr];
    end

    // UART RX FIFO model
    logic [7:0] fifo_mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    int         n_push = 0;
    int         n_pop = 0;
    int         pop_err = 0;

    assign rx_empty = (wr_ptr == rd_ptr);
    assign rx_data  = fifo_mem[rd_ptr];

    always @(posedge clk) begin
        if (rd_uart) begin
            n_pop <= n_pop + 1;
            if (rx_empty) pop_err <= pop_err + 1;
            else rd_ptr <= rd_ptr + 8'd1;
        end
    end

    // Reference screen and cursor
    logic [6:0] scr [0:ROWS-1][0:COLS-1];
    int         cx;
    int         cy;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_newline();
        if (cy < ROWS - 1) begin
            cy++;
        end else begin
            for (int r = 1; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) scr[r-1][c] = scr[r][c];
            for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = BLK;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if ((b >= 8'h20) && (b <= 8'h7E)) begin
            scr[cy][cx] = b[6:0];
            if (cx == COLS - 1) begin
                cx = 0;
                model_newline();
            end else begin
                cx++;
            end
        end else if (b == 8'h0D) begin
            cx = 0;
        end else if (b == 8'h0A) begin
            model_newline();
        end else if (b == 8'h08) begin
            if (cx > 0) begin
                cx--;
                scr[cy][cx] = BLK;
            end
        end else if (b == 8'h0C) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = BLK;
            cx = 0;
            cy = 0;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
        n_push++;
        model_byte(b);
    endtask

    task automatic tick(input logic r, input logic d);
        @(negedge clk);
        key_right = r;
        key_down  = d;
        @(negedge clk);
        key_right = 1'b0;
        key_down  = 1'b0;
        if (r) cx = (cx == COLS - 1) ? 0 : cx + 1;
        else if (d) cy = (cy == ROWS - 1) ? 0 : cy + 1;
    endtask

    // Wait for FIFO drained and DUT idle; optionally fire a key tick mid-operation
    task automatic wait_idle(input bit poke, output int nbusy);
        bit ok = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 30000; i++) begin
            @(negedge clk);
            key_right = 1'b0;
            if (busy) nbusy++;
            if (poke && busy && nbusy == 50) key_right = 1'b1;
            if (rx_empty && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic load_screen();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r*128 + c] = scr[r][c];
        @(negedge clk);
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
    endtask

    task automatic random_screen();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 7'($urandom_range(33, 126));
        load_screen();
    endtask

    task automatic compare_screen(input string tag);
        int nbad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mem[r*128 + c] !== scr[r][c]) nbad++;
        check(tag, 32'(nbad), 32'd0);
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_x"}, 32'(cur_x), 32'(cx));
        check({tag, "_y"}, 32'(cur_y), 32'(cy));
    endtask

    function automatic logic [7:0] rand_byte();
        int r = $urandom_range(0, 99);
        if (r < 62) return 8'($urandom_range(32, 126));
        if (r < 72) return 8'h0D;
        if (r < 79) return 8'h0A;
        if (r < 89) return 8'h08;
        if (r < 90) return 8'h0C;
        if (r < 95) return 8'($urandom_range(128, 255));
        return 8'($urandom_range(0, 31));
    endfunction

    initial begin
        int nb;
        int p0;
        int w0;
        logic [6:0] keep;

        rst_n     = 1'b0;
        key_right = 1'b0;
        key_down  = 1'b0;
        random_screen();

        // Reset values
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_uart", 32'(rd_uart), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_cur_x", 32'(cur_x), 32'd0);
        check("rst_cur_y", 32'(cur_y), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cx = 0;
        cy = 0;

        // "AB" at the origin
        p0 = n_pop;
        push_byte(8'h41);
        push_byte(8'h42);
        wait_idle(1'b0, nb);
        check("ab_cell0", 32'(mem[0]), 32'h41);
        check("ab_cell1", 32'(mem[1]), 32'h42);
        check("ab_cur_x", 32'(cur_x), 32'd2);
        check("ab_cur_y", 32'(cur_y), 32'd0);
        check("ab_pops", 32'(n_pop - p0), 32'd2);

        // Printable byte in the last column wraps to the next row
        for (int i = 0; i < 77; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        check_cursor("pre_z");
        push_byte(8'h5A);
        wait_idle(1'b0, nb);
        check("z_cell", 32'(mem[5*128 + 79]), 32'h5A);
        check("z_cur_x", 32'(cur_x), 32'd0);
        check("z_cur_y", 32'(cur_y), 32'd6);

        // LF on the bottom row scrolls everything up one row
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scr[r][c] = 7'(8'h30 + r);
        load_screen();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 23; i++) tick(1'b0, 1'b1);
        push_byte(8'h0A);
        wait_idle(1'b0, nb);
        // decode cycle plus the read/write copy of 29 rows and the blank row
        check("lf_busy_len", 32'(nb), 32'(2*COLS*(ROWS-1) + COLS + 1));
        check("lf_row0", 32'(mem[0*128 + 17]), 32'h31);
        check("lf_row28", 32'(mem[28*128 + 79]), 32'h4D);
        check("lf_row29", 32'(mem[29*128 + 40]), 32'h20);
        compare_screen("lf_screen");
        check("lf_cur_x", 32'(cur_x), 32'd3);
        check("lf_cur_y", 32'(cur_y), 32'd29);

        // FF clears the screen; a key tick during the clear is dropped
        for (int i = 0; i < 37; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 13; i++) tick(1'b0, 1'b1);
        check_cursor("pre_ff");
        push_byte(8'h0C);
        wait_idle(1'b1, nb);
        check("ff_busy_in_range", 32'((nb >= 2398) && (nb <= 2402)), 32'd1);
        compare_screen("ff_screen");
        check("ff_cur_x", 32'(cur_x), 32'd0);
        check("ff_cur_y", 32'(cur_y), 32'd0);

        // Backspace at column 0 and mid-row, then CR and a double key tick
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1);
        w0 = n_wr;
        push_byte(8'h08);
        wait_idle(1'b0, nb);
        check("bs0_writes", 32'(n_wr - w0), 32'd0);
        check_cursor("bs0");
        random_screen();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        push_byte(8'h08);
        wait_idle(1'b0, nb);
        check("bs5_cell", 32'(mem[7*128 + 4]), 32'h20);
        check("bs5_cur_x", 32'(cur_x), 32'd4);
        check("bs5_cur_y", 32'(cur_y), 32'd7);
        push_byte(8'h0D);
        wait_idle(1'b0, nb);
        tick(1'b1, 1'b1);
        check("both_keys_x", 32'(cur_x), 32'd1);
        check("both_keys_y", 32'(cur_y), 32'd7);
        compare_screen("bs_screen");

        // Random bursts against the reference model
        for (int k = 0; k < 7; k++) begin
            int nk = $urandom_range(0, 6);
            for (int i = 0; i < nk; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 16; i++) push_byte(rand_byte());
            wait_idle(1'b0, nb);
            compare_screen($sformatf("rand%0d_screen", k));
            check_cursor($sformatf("rand%0d_cur", k));
        end

        // Reset at cell 1000 of a clear aborts it and keeps the partial RAM contents
        random_screen();
        keep = scr[25][0];
        push_byte(8'h0C);
        nb = 0;
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        check("abort_started", 32'(busy), 32'd1);
        repeat (1001) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cur_x", 32'(cur_x), 32'd0);
        check("abort_cur_y", 32'(cur_y), 32'd0);
        check("abort_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_cell0", 32'(mem[0]), 32'h20);
        check("abort_cell_kept", 32'(mem[25*128]), 32'(keep));
        cx = 0;
        cy = 0;
        push_byte(8'h51);
        wait_idle(1'b0, nb);
        check("after_abort_cell", 32'(mem[0]), 32'h51);
        check("after_abort_cur_x", 32'(cur_x), 32'd1);
        check("after_abort_cur_y", 32'(cur_y), 32'd0);

        // Global invariants
        @(negedge clk);
        check("bad_addr_writes", 32'(bad_wr), 32'd0);
        check("pop_when_empty", 32'(pop_err), 32'd0);
        check("pops_per_byte", 32'(n_pop), 32'(n_push));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
